tile_streamer: RTL

TILE_STREAMER -- requirements
Module: tile_streamer

---
 rtl/tile_streamer_if.sv | 31 +++
 rtl/tile_streamer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/tile_streamer_if.sv
// Control, memory-read and stream signals of the tile streamer, bundled for port use.
// The master view belongs to the streamer; the slave view to its environment.
interface tile_streamer_if #(
    parameter int W  = 16,
    parameter int AW = 7
) ();
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;

    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [W-1:0]  mem_rd_data;

    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    modport master (
        input  start, base_addr, length, mem_rd_data, m_ready,
        output busy, done, mem_rd_en, mem_rd_addr, m_data, m_valid, m_last
    );

    modport slave (
        output start, base_addr, length, mem_rd_data, m_ready,
        input  busy, done, mem_rd_en, mem_rd_addr, m_data, m_valid, m_last
    );
endinterface

// File: rtl/tile_streamer.sv
// Streams a run of consecutive memory words (wrapping address) as a valid/ready beat stream,
// with a two-entry skid buffer that bounds reads in flight plus buffered words to two.
module tile_streamer #(
    parameter int W  = 16,
    parameter int AW = 7
) (
    input  logic           clk,
    input  logic           rst,
    tile_streamer_if.master bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_reg;
    logic [AW-1:0] rd_addr_reg;
    logic [AW:0]   rd_remaining_reg;
    logic          inflight_reg;
    logic          inflight_last_reg;
    logic          out_valid_reg;
    logic          out_last_reg;
    logic [W-1:0]  out_data_reg;
    logic          skid_valid_reg;
    logic          skid_last_reg;
    logic [W-1:0]  skid_data_reg;
    logic          done_reg;

    logic [1:0]    occupancy;
    logic          issue;
    logic          beat_valid;
    logic [W-1:0]  beat_data;
    logic          beat_last;
    logic          handshake;

    assign occupancy = {1'b0, inflight_reg} + {1'b0, out_valid_reg} + {1'b0, skid_valid_reg};
    assign issue     = (state_reg == RUN) && (rd_remaining_reg != '0) && (occupancy < 2'd2);

    // Read data lands in the cycle m_valid must already be up, so an empty buffer
    // forwards the arriving word directly; it is captured if not taken that cycle.
    assign beat_valid = out_valid_reg || inflight_reg;
    assign beat_data  = out_valid_reg ? out_data_reg
                      : (inflight_reg ? bus.mem_rd_data : '0);
    assign beat_last  = out_valid_reg ? out_last_reg : (inflight_reg && inflight_last_reg);
    assign handshake  = beat_valid && bus.m_ready;

    assign bus.busy        = (state_reg == RUN);
    assign bus.done        = done_reg;
    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = rd_addr_reg;
    assign bus.m_data      = beat_data;
    assign bus.m_valid     = beat_valid;
    assign bus.m_last      = beat_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            rd_addr_reg       <= '0;
            rd_remaining_reg  <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            out_valid_reg     <= 1'b0;
            out_last_reg      <= 1'b0;
            out_data_reg      <= '0;
            skid_valid_reg    <= 1'b0;
            skid_last_reg     <= 1'b0;
            skid_data_reg     <= '0;
            done_reg          <= 1'b0;
        end else begin
            done_reg          <= 1'b0;
            inflight_reg      <= issue;
            inflight_last_reg <= issue && (rd_remaining_reg == (AW+1)'(1));

            if (issue) begin
                rd_addr_reg      <= rd_addr_reg + 1'b1;
                rd_remaining_reg <= rd_remaining_reg - 1'b1;
            end

            // Head entry drains first; the skid entry only fills while the head is held.
            if (out_valid_reg) begin
                if (handshake) begin
                    if (skid_valid_reg) begin
                        out_data_reg   <= skid_data_reg;
                        out_last_reg   <= skid_last_reg;
                        skid_valid_reg <= inflight_reg;
                        skid_data_reg  <= bus.mem_rd_data;
                        skid_last_reg  <= inflight_last_reg;
                    end else if (inflight_reg) begin
                        out_data_reg <= bus.mem_rd_data;
                        out_last_reg <= inflight_last_reg;
                    end else begin
                        out_valid_reg <= 1'b0;
                    end
                end else if (inflight_reg) begin
                    skid_valid_reg <= 1'b1;
                    skid_data_reg  <= bus.mem_rd_data;
                    skid_last_reg  <= inflight_last_reg;
                end
            end else if (inflight_reg && !bus.m_ready) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= bus.mem_rd_data;
                out_last_reg  <= inflight_last_reg;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.length != '0) begin
                            state_reg        <= RUN;
                            rd_addr_reg      <= bus.base_addr;
                            rd_remaining_reg <= bus.length;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (handshake && beat_last) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
